// File: rtl/maxnet_iterator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : maxnet_iterator                                              |
// | Description : Iterative winner-take-all engine. Loads four sign-magnitude  |
// |               activations, applies lateral inhibition with ReLU clamping   |
// |               (Jacobi update, one shared subtract path, 6 cycles/iter)     |
// |               until one or zero activations remain non-zero.               |
// | Option      : MAXNET_ITER_LIMIT_EN - enables the MAX_ITER timeout check.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module maxnet_iterator #(
   parameter int EPS_SHIFT = 2,
   parameter int MAX_ITER  = 255,
   parameter int ITER_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       X1,
   input  logic [31:0]       X2,
   input  logic [31:0]       X3,
   input  logic [31:0]       X4,
   output logic [31:0]       A1,
   output logic [31:0]       A2,
   output logic [31:0]       A3,
   output logic [31:0]       A4,
   output logic              busy,
   output logic              iter_valid,
   output logic              done,
   output logic [1:0]        status,
   output logic [ITER_W-1:0] iter_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SUM   = 2'd1,
      UPD   = 2'd2,
      CHECK = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [31:0]       act [4];
   logic [32:0]       sum_r;
   logic [1:0]        idx;

   logic [32:0]       cur;
   logic [32:0]       resid;
   logic [32:0]       inh;
   logic [31:0]       upd_val;
   logic [2:0]        n_nz;
   logic [ITER_W-1:0] iter_inc;
   logic              limit_hit;
   logic              finish;
   logic [1:0]        fin_code;

   assign A1 = act[0];
   assign A2 = act[1];
   assign A3 = act[2];
   assign A4 = act[3];

   // Shared inhibition path: update value for the activation selected by idx.
   always_comb begin
      cur   = {1'b0, act[idx]};
      resid = sum_r - cur;
      inh   = resid >> EPS_SHIFT;
      // A tiny residual would shift to zero and stall convergence; force 1.
      if (resid != '0 && inh == '0) begin
         inh = 33'd1;
      end
      upd_val = (cur > inh) ? (act[idx] - inh[31:0]) : '0;
   end

   // Completion decision evaluated during CHECK.
   always_comb begin
      n_nz = '0;
      for (int i = 0; i < 4; i++) begin
         n_nz = n_nz + 3'(act[i] != '0);
      end
      iter_inc = (iter_count == '1) ? iter_count : iter_count + ITER_W'(1);
`ifdef MAXNET_ITER_LIMIT_EN
      limit_hit = (iter_inc == ITER_W'(MAX_ITER));
`else
      // Limit disabled: comparator tied off, run ends only on 0 or 1 survivors.
      limit_hit = 1'b0 && (iter_inc == ITER_W'(MAX_ITER));
`endif
      finish   = 1'b0;
      fin_code = 2'b00;
      if (n_nz == 3'd1) begin
         finish   = 1'b1;
         fin_code = 2'b00;
      end else if (n_nz == 3'd0) begin
         finish   = 1'b1;
         fin_code = 2'b01;
      end else if (limit_hit) begin
         finish   = 1'b1;
         fin_code = 2'b10;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_nx   = state;
      busy       = (state != IDLE);
      iter_valid = (state == CHECK);
      unique case (state)
         IDLE:  if (start) state_nx = SUM;
         SUM:   state_nx = UPD;
         UPD:   if (idx == 2'd3) state_nx = CHECK;
         CHECK: state_nx = finish ? IDLE : SUM;
      endcase
   end

   // Datapath registers: load, sum, per-index update, iteration bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            act[i] <= '0;
         end
         sum_r      <= '0;
         idx        <= '0;
         status     <= 2'b00;
         iter_count <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  // Negative inputs are clamped to zero on load.
                  act[0]     <= X1[31] ? '0 : {1'b0, X1[30:0]};
                  act[1]     <= X2[31] ? '0 : {1'b0, X2[30:0]};
                  act[2]     <= X3[31] ? '0 : {1'b0, X3[30:0]};
                  act[3]     <= X4[31] ? '0 : {1'b0, X4[30:0]};
                  iter_count <= '0;
                  status     <= 2'b00;
               end
            end
            SUM: begin
               sum_r <= {1'b0, act[0]} + {1'b0, act[1]} + {1'b0, act[2]} + {1'b0, act[3]};
               idx   <= 2'd0;
            end
            UPD: begin
               act[idx] <= upd_val;
               idx      <= idx + 2'd1;
            end
            CHECK: begin
               iter_count <= iter_inc;
               if (finish) begin
                  status <= fin_code;
               end
               done <= finish;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_maxnet_iterator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_maxnet_iterator                                           |
// | Description : Self-checking bench for maxnet_iterator with a vector-level  |
// |               Jacobi model and cycle-accurate protocol checks.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_maxnet_iterator;

   localparam int EPS_SHIFT = 2;
   localparam int MAX_ITER  = 255;
   localparam int ITER_W    = 8;
   localparam int MAXK      = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [31:0]       X1 = '0, X2 = '0, X3 = '0, X4 = '0;
   logic [31:0]       A1, A2, A3, A4;
   logic              busy, iter_valid, done;
   logic [1:0]        status;
   logic [ITER_W-1:0] iter_count;

   maxnet_iterator #(
      .EPS_SHIFT (EPS_SHIFT),
      .MAX_ITER  (MAX_ITER),
      .ITER_W    (ITER_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .X1         (X1),
      .X2         (X2),
      .X3         (X3),
      .X4         (X4),
      .A1         (A1),
      .A2         (A2),
      .A3         (A3),
      .A4         (A4),
      .busy       (busy),
      .iter_valid (iter_valid),
      .done       (done),
      .status     (status),
      .iter_count (iter_count)
   );

   always #5 clk = ~clk;

   int           total = 0;
   int           bad   = 0;
   logic [127:0] exp_vec_r [0:MAXK];
   logic [127:0] cap_vec   [0:MAXK];
   int           exp_k = 0;
   logic [1:0]   exp_status = 2'b00;
   bit           tracking = 1'b0;
   int           t = 0;
   int           kk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0d, time=%0t)", name, got, want, t, $time);
      end
   endtask

   // Vector-level model: simultaneous inhibition of all four activations per iteration.
   task automatic model_run(input logic [31:0] x1, input logic [31:0] x2,
                            input logic [31:0] x3, input logic [31:0] x4);
      longint      a [4];
      longint      na [4];
      longint      s, r, inh;
      int          nz;
      bit          stop;
      logic [31:0] xin [4];
      xin = '{x1, x2, x3, x4};
      for (int i = 0; i < 4; i++) begin
         a[i] = xin[i][31] ? 64'sd0 : longint'({33'd0, xin[i][30:0]});
      end
      exp_k = 0;
      nz    = 0;
      do begin
         s = a[0] + a[1] + a[2] + a[3];
         for (int i = 0; i < 4; i++) begin
            r   = s - a[i];
            inh = r / (64'sd1 << EPS_SHIFT);
            if (r != 0 && inh == 0) inh = 1;
            na[i] = (a[i] > inh) ? a[i] - inh : 64'sd0;
         end
         a = na;
         exp_k++;
         exp_vec_r[exp_k] = {a[0][31:0], a[1][31:0], a[2][31:0], a[3][31:0]};
         nz = 0;
         for (int i = 0; i < 4; i++) if (a[i] != 0) nz++;
         stop = (nz <= 1) || (exp_k >= MAXK);
`ifdef MAXNET_ITER_LIMIT_EN
         if (exp_k == MAX_ITER) stop = 1'b1;
`endif
      end while (!stop);
      exp_status = (nz == 1) ? 2'b00 : (nz == 0) ? 2'b01 : 2'b10;
   endtask

   // Single compare process: protocol timing and activation values every cycle.
   always @(negedge clk) begin
      if (tracking) begin
         chk("busy", 128'(busy), 128'(t < 6 * exp_k));
         chk("iter_valid", 128'(iter_valid), 128'((t % 6 == 5) && (t < 6 * exp_k)));
         chk("done", 128'(done), 128'(t == 6 * exp_k));
         if (t < 6 * exp_k) chk("iter_count_run", 128'(iter_count), 128'(t / 6));
         if ((t % 6 == 5) && (t < 6 * exp_k)) begin
            kk = t / 6 + 1;
            chk("A_at_iter_valid", {A1, A2, A3, A4}, exp_vec_r[kk]);
            cap_vec[kk] = {A1, A2, A3, A4};
         end
         if (t == 6 * exp_k) begin
            chk("status_at_done", 128'(status), 128'(exp_status));
            chk("iter_count_at_done", 128'(iter_count), 128'(exp_k));
            chk("A_at_done", {A1, A2, A3, A4}, exp_vec_r[exp_k]);
            tracking = 1'b0;
         end
         t++;
      end else begin
         chk("idle_busy", 128'(busy), 128'(0));
         chk("idle_iter_valid", 128'(iter_valid), 128'(0));
         chk("idle_done", 128'(done), 128'(0));
      end
   end

   task automatic launch(input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] x3, input logic [31:0] x4);
      model_run(x1, x2, x3, x4);
      @(negedge clk);
      X1 = x1; X2 = x2; X3 = x3; X4 = x4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      t        = 0;
      tracking = 1'b1;
   endtask

   task automatic run_case(input logic [31:0] x1, input logic [31:0] x2,
                           input logic [31:0] x3, input logic [31:0] x4, input bit extra_start);
      launch(x1, x2, x3, x4);
      if (extra_start) begin
         repeat (3) @(posedge clk);
         #1;
         X1 = 32'h0000_1234; X2 = 32'h7FFF_0000;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      for (int c = 0; c < 6 * MAXK + 20 && tracking; c++) @(posedge clk);
      if (tracking) begin
         total++;
         bad++;
         $display("FAIL timeout: done not seen, got=none want=done within %0d cycles", 6 * MAXK + 20);
         tracking = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got=stuck want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_A", {A1, A2, A3, A4}, 128'd0);
      chk("rst_status", 128'(status), 128'd0);
      chk("rst_iter_count", 128'(iter_count), 128'd0);
      rst_n = 1'b1;

      // Worked example: (100,40,20,10)
      run_case(32'd100, 32'd40, 32'd20, 32'd10, 1'b0);
      chk("lit_iter1_A", cap_vec[1], {32'd83, 32'd8, 32'd0, 32'd0});
      chk("lit_final_A", {A1, A2, A3, A4}, {32'd81, 32'd0, 32'd0, 32'd0});
      chk("lit_status_winner", 128'(status), 128'd0);
      chk("lit_iter_count_2", 128'(iter_count), 128'd2);

      // Negative input clamps
      run_case(32'h8000_0064, 32'd30, 32'd0, 32'd0, 1'b0);
      chk("lit_neg_A", {A1, A2, A3, A4}, {32'd0, 32'd30, 32'd0, 32'd0});
      chk("lit_neg_count", 128'(iter_count), 128'd1);
      chk("lit_neg_status", 128'(status), 128'd0);

      // Tie collapses to zero; stray start pulses during busy are ignored
      run_case(32'd50, 32'd50, 32'd0, 32'd0, 1'b1);
      chk("lit_tie_status", 128'(status), 128'd1);
      chk("lit_tie_A", {A1, A2, A3, A4}, 128'd0);

      // All-zero input still runs one iteration
      run_case(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk("lit_zero_status", 128'(status), 128'd1);
      chk("lit_zero_count", 128'(iter_count), 128'd1);

      // Full-scale magnitudes exercise the 33-bit sum
      run_case(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      run_case(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd3, 1'b0);
      chk("lit_big_A", {A1, A2, A3, A4}, {32'd0, 32'h7FFF_FFFD, 32'd0, 32'd0});
      run_case(32'd5, 32'd4, 32'd3, 32'd2, 1'b0);

      // Asynchronous reset in the middle of UPD
      launch(32'd100, 32'd40, 32'd20, 32'd10);
      repeat (2) @(posedge clk);
      #2;
      tracking = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("abort_A", {A1, A2, A3, A4}, 128'd0);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_done", 128'(done), 128'd0);
      chk("abort_iter_count", 128'(iter_count), 128'd0);
      chk("abort_status", 128'(status), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Normal run after release
      run_case(32'd100, 32'd40, 32'd20, 32'd10, 1'b0);
      chk("lit_rerun_A", {A1, A2, A3, A4}, {32'd81, 32'd0, 32'd0, 32'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/maxnet_iterator.md
# maxnet_iterator

Iterative winner-take-all engine for the neural-network datapath. It loads four 32-bit activations, repeatedly applies lateral inhibition with ReLU clamping, and drives the four `A1`..`A4` activation buses consumed by the winner-index decoder. It reports when exactly one activation remains non-zero, when all have collapsed to zero, or when an iteration limit is hit.

## Interface
- `EPS_SHIFT`, default 2: inhibition weight is eps = 2^-EPS_SHIFT. The default 1/4 is below 1/(4-1).
- `MAX_ITER`, default 255: iteration limit, used only when the limit feature is compiled in.
- `ITER_W`, default 8: width of the iteration counter. It must hold `MAX_ITER`.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: load `X1`..`X4` and begin. Sampled only in IDLE.
- `X1`..`X4`, in, 32 each: sign-magnitude inputs. Bit 31 is the sign; [30:0] is the magnitude.
- `A1`..`A4`, out, 32 each: activation registers. Bit 31 is always 0.
- `busy`, out, 1: high in every state except IDLE.
- `iter_valid`, out, 1: high for the one CHECK cycle of each iteration. `A1`..`A4` are stable and consistent in that cycle.
- `done`, out, 1: registered one-cycle pulse on completion.
- `status`, out, 2: completion code, valid from `done` until the next `start`.
  - 00: single winner.
  - 01: all activations zero.
  - 10: timeout.
- `iter_count`, out, `ITER_W`: number of completed iterations for the current run.

## Operation
- **States:** IDLE, SUM, UPD, CHECK. `idx` is a 2-bit counter, 0..3, used in UPD.
- **IDLE, `start`=1:**
  - Load `A`i = {1'b0, `X`i[30:0]}. If `X`i[31]=1, load 0 instead (negative inputs are clamped).
  - Clear `iter_count` and `status`.
  - Next state: SUM.
- **SUM:**
  - S = `A1`+`A2`+`A3`+`A4`, registered at 33 bits with no overflow.
  - `idx` := 0. Next state: UPD.
- **UPD (4 cycles, `idx` 0..3):** one shared subtract/compare path updates `A[idx]`.
  - r = S − `A[idx]`.
  - inh = r >> `EPS_SHIFT`. If r ≠ 0 and inh = 0, inh := 1 (this guarantees progress).
  - `A[idx]` := (`A[idx]` > inh) ? `A[idx]` − inh : 0.
  - Every update uses the S computed in SUM, so the result equals a simultaneous (Jacobi) update.
  - After `idx`=3, go to CHECK.
- **CHECK:**
  - Increment `iter_count`. Count the non-zero activations, n.
  - n=1: `status`=00, go to IDLE, pulse `done`.
  - n=0: `status`=01, go to IDLE, pulse `done`.
  - Otherwise, if the limit is compiled in and the incremented count equals `MAX_ITER`: `status`=10, go to IDLE, pulse `done`.
  - Otherwise go to SUM.
- At least one iteration always runs. An input that already has a single winner still completes one iteration.
- `start` while `busy` is ignored.

## Timing
- Reset values: all `A`=0, `busy`=0, `iter_valid`=0, `done`=0, `status`=00, `iter_count`=0, state IDLE.
- Reset is asynchronous and active-low. It aborts any run immediately; no `done` pulse is produced.
- Each iteration takes 6 cycles: SUM, UPD×4, CHECK.
- With `start` sampled at edge 0:
  - SUM after edge 0.
  - `A1` changes at edge 2, `A2` at edge 3, `A3` at edge 4, `A4` at edge 5.
  - `iter_valid` is high in the cycle after edge 5.
- Iteration k ends in CHECK during the cycle after edge 6k−1. `done` is high during the cycle after edge 6k.
- Between iteration boundaries, `A1`..`A4` are partially updated. Consumers must qualify them with `iter_valid` or `done`.

## Configuration
- `MAXNET_ITER_LIMIT_EN`
  - Defined: CHECK enforces `MAX_ITER`, and `status`=10 is reachable.
  - Undefined: there is no limit check. The run ends only with 00 or 01, which the forced minimum inhibition guarantees. `iter_count` still counts and saturates at all-ones.

## Test plan
- `X`=(100,40,20,10):
  - After iteration 1, `A`=(83,8,0,0).
  - After iteration 2, `A`=(81,0,0,0).
  - `status`=00, `iter_count`=2, `done` 12 cycles after `start` is sampled.
- `X`=(0x8000_0064,30,0,0): the negative value clamps to 0; `A`=(0,30,0,0) after 1 iteration, `status`=00, `iter_count`=1.
- `X`=(50,50,0,0): both activations decay identically, giving `A`=(0,0,0,0) and `status`=01. `X`=(0,0,0,0) gives `status`=01 after 1 iteration.
- With the limit enabled, `MAX_ITER`=1 and `X`=(100,40,20,10): `status`=10 and `A`=(83,8,0,0).
- Protocol:
  - `start` pulses during `busy` are ignored.
  - Deasserting `rst_n` in the middle of UPD clears all outputs at once, with no `done`.
  - A new `start` after release runs normally.
